conv2d_mc: RTL and testbench

CONV2D_MC -- requirements
Module: conv2d_mc

---
 rtl/conv2d_mc.sv | 196 +++++++++++++++++++
 tb/tb_conv2d_mc.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_mc.sv
// conv2d_mc: multi-channel 2-D convolution engine.
// Software fills the image and kernel byte memories, programs the geometry and
// pulses start. One signed 8x8 MAC is done per cycle (kx innermost, then ky,
// then channel). After the last tap of a pixel, one writeback cycle shifts,
// optionally rectifies and saturates the accumulator into the output byte memory.
//
// state  | meaning
// IDLE   | waiting for start; mi/mk writes accepted
// CALC   | one MAC per cycle for the current output pixel
// WB     | write the result byte, clear the accumulator, step to the next pixel
// FIN    | one-cycle done pulse, then back to IDLE
module conv2d_mc #(
    parameter int DSIZE = 4096,
    parameter int KSIZE = 5,
    parameter int CMAX  = 4,
    parameter int ACCW  = 24,
    localparam int AW   = $clog2(DSIZE),
    localparam int KDEP = CMAX * KSIZE * KSIZE,
    localparam int KAW  = $clog2(KDEP)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     data_width,
    input  logic [7:0]     data_height,
    input  logic [7:0]     result_width,
    input  logic [7:0]     result_height,
    input  logic [2:0]     channels,
    input  logic [3:0]     kernel_width,
    input  logic [3:0]     kernel_height,
    input  logic [3:0]     stride_x,
    input  logic [3:0]     stride_y,
    input  logic [1:0]     pad,
    input  logic [4:0]     shift,
    input  logic           relu_en,
    input  logic [AW-1:0]  mi_addr,
    input  logic [7:0]     mi_data,
    input  logic           mi_wr,
    input  logic [KAW-1:0] mk_addr,
    input  logic [7:0]     mk_data,
    input  logic           mk_wr,
    input  logic [AW-1:0]  mo_addr,
    output logic [31:0]    mo_data,
    input  logic           start,
    output logic           busy,
    output logic           done
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WB, S_FIN} state_t;

    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(127);
    localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-128);

    logic [7:0] img_mem [DSIZE];
    logic [7:0] ker_mem [KDEP];
    logic [7:0] out_mem [DSIZE];

    state_t                 state_q;
    logic [3:0]             kx_q, ky_q;
    logic [2:0]             ch_q;
    logic [7:0]             ox_q, oy_q;
    logic signed [ACCW-1:0] acc_q;
    logic                   busy_q, done_q;

    logic signed [31:0]     ix_s, iy_s;
    logic                   tap_in;
    logic [AW-1:0]          img_addr;
    logic [KAW-1:0]         ker_addr;
    logic signed [7:0]      tap_val, ker_val;
    logic signed [15:0]     prod;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] shr, res_c;
    logic [7:0]             out_byte_d;
    logic [AW-1:0]          out_addr;
    logic                   kx_last, ky_last, ch_last, tap_last, ox_last, oy_last;

    // Tap coordinates, padding test, memory addressing and the MAC sum.
    always_comb begin
        ix_s = $signed(32'(ox_q) * 32'(stride_x) + 32'(kx_q) - 32'(pad));
        iy_s = $signed(32'(oy_q) * 32'(stride_y) + 32'(ky_q) - 32'(pad));
        tap_in = (ix_s >= 0) && (ix_s < $signed(32'(data_width))) &&
                 (iy_s >= 0) && (iy_s < $signed(32'(data_height)));
        // Padding taps never touch the image memory.
        img_addr = tap_in ? AW'(32'(ch_q) * 32'(data_width) * 32'(data_height)
                               + $unsigned(iy_s) * 32'(data_width) + $unsigned(ix_s))
                          : '0;
        ker_addr = KAW'(32'(ch_q) * 32'(KSIZE * KSIZE) + 32'(ky_q) * 32'(KSIZE) + 32'(kx_q));
        tap_val  = tap_in ? $signed(img_mem[img_addr]) : 8'sd0;
        ker_val  = $signed(ker_mem[ker_addr]);
        prod     = $signed({{8{tap_val[7]}}, tap_val}) * $signed({{8{ker_val[7]}}, ker_val});
        acc_d    = acc_q + {{(ACCW-16){prod[15]}}, prod};
    end

    // Writeback chain (shift, ReLU, saturate), output address and loop terminals.
    always_comb begin
        shr   = acc_q >>> shift;
        res_c = (relu_en && shr[ACCW-1]) ? '0 : shr;
        if (res_c > SAT_HI)      out_byte_d = 8'h7F;
        else if (res_c < SAT_LO) out_byte_d = 8'h80;
        else                     out_byte_d = res_c[7:0];
        out_addr = AW'(32'(oy_q) * 32'(result_width) + 32'(ox_q));
        kx_last  = (kx_q == kernel_width - 4'd1);
        ky_last  = (ky_q == kernel_height - 4'd1);
        ch_last  = (ch_q == channels - 3'd1);
        tap_last = kx_last && ky_last && ch_last;
        ox_last  = (ox_q == result_width - 8'd1);
        oy_last  = (oy_q == result_height - 8'd1);
    end

    // Sequencer: state, loop counters, accumulator and registered status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kx_q    <= '0;
            ky_q    <= '0;
            ch_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                        kx_q    <= '0;
                        ky_q    <= '0;
                        ch_q    <= '0;
                        ox_q    <= '0;
                        oy_q    <= '0;
                        acc_q   <= '0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    if (tap_last) begin
                        state_q <= S_WB;
                        kx_q    <= '0;
                        ky_q    <= '0;
                        ch_q    <= '0;
                    end else if (!kx_last) begin
                        kx_q <= kx_q + 4'd1;
                    end else if (!ky_last) begin
                        kx_q <= '0;
                        ky_q <= ky_q + 4'd1;
                    end else begin
                        kx_q <= '0;
                        ky_q <= '0;
                        ch_q <= ch_q + 3'd1;
                    end
                end
                S_WB: begin
                    acc_q <= '0;
                    if (ox_last && oy_last) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_CALC;
                        if (ox_last) begin
                            ox_q <= '0;
                            oy_q <= oy_q + 8'd1;
                        end else begin
                            ox_q <= ox_q + 8'd1;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Image byte write port, locked out while a run is in progress.
    always_ff @(posedge clk) begin
        if (mi_wr && !busy_q) img_mem[mi_addr] <= mi_data;
    end

    // Kernel byte write port, locked out while busy and past the end of the array.
    always_ff @(posedge clk) begin
        if (mk_wr && !busy_q && (32'(mk_addr) < 32'(KDEP))) ker_mem[mk_addr] <= mk_data;
    end

    // Output byte write in WB; an edge with reset asserted writes nothing.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_WB) out_mem[out_addr] <= out_byte_d;
    end

    assign mo_data = {out_mem[mo_addr + AW'(3)], out_mem[mo_addr + AW'(2)],
                      out_mem[mo_addr + AW'(1)], out_mem[mo_addr]};
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_conv2d_mc.sv
// Scoreboard bench for conv2d_mc: stimulus computes expected output bytes and
// busy-cycle counts from a direct convolution model and queues them; a monitor
// drains the queue through the mo port whenever a run finishes.
`timescale 1ns/1ps
module tb_conv2d_mc;
    localparam int DSIZE = 4096;
    localparam int KSIZE = 5;
    localparam int CMAX  = 4;
    localparam int ACCW  = 24;
    localparam int AW    = 12;
    localparam int KAW   = 7;
    localparam int KDEP  = CMAX * KSIZE * KSIZE;

    logic           clk, rst_n;
    logic [7:0]     data_width, data_height, result_width, result_height;
    logic [2:0]     channels;
    logic [3:0]     kernel_width, kernel_height, stride_x, stride_y;
    logic [1:0]     pad;
    logic [4:0]     shift;
    logic           relu_en;
    logic [AW-1:0]  mi_addr, mo_addr;
    logic [7:0]     mi_data, mk_data;
    logic           mi_wr, mk_wr;
    logic [KAW-1:0] mk_addr;
    logic [31:0]    mo_data;
    logic           start, busy, done;

    conv2d_mc #(.DSIZE(DSIZE), .KSIZE(KSIZE), .CMAX(CMAX), .ACCW(ACCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_width(data_width), .data_height(data_height),
        .result_width(result_width), .result_height(result_height),
        .channels(channels), .kernel_width(kernel_width), .kernel_height(kernel_height),
        .stride_x(stride_x), .stride_y(stride_y), .pad(pad), .shift(shift), .relu_en(relu_en),
        .mi_addr(mi_addr), .mi_data(mi_data), .mi_wr(mi_wr),
        .mk_addr(mk_addr), .mk_data(mk_data), .mk_wr(mk_wr),
        .mo_addr(mo_addr), .mo_data(mo_data),
        .start(start), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          addr;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    int  cyc_q[$];
    int  errors = 0;
    int  checks = 0;
    int  runs_done = 0;
    int  req_cnt = 0;
    int  ack_cnt = 0;

    byte img [DSIZE];
    byte ker [KDEP];
    int  mdl_out [DSIZE];
    int  c_dw, c_dh, c_rw, c_rh, c_nc, c_kw, c_kh, c_sx, c_sy, c_pd, c_sh, c_relu;

    task automatic check(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void push_entry(string nm, int a, logic [31:0] e, logic [31:0] m);
        sb_t s;
        s.addr = a;
        s.exp  = e;
        s.mask = m;
        s.name = nm;
        sb_q.push_back(s);
    endfunction

    function automatic void push_byte(string nm, int a, int v);
        push_entry($sformatf("%s_px%0d", nm, a), a, 32'(v & 255), 32'hFF);
    endfunction

    // Direct convolution from the geometry rules, with 24-bit wrap and the writeback chain.
    function automatic void model_job(string nm);
        for (int oy = 0; oy < c_rh; oy++) begin
            for (int ox = 0; ox < c_rw; ox++) begin
                longint sum = 0;
                longint acc;
                longint r;
                for (int c = 0; c < c_nc; c++)
                    for (int ky = 0; ky < c_kh; ky++)
                        for (int kx = 0; kx < c_kw; kx++) begin
                            int ix = ox * c_sx + kx - c_pd;
                            int iy = oy * c_sy + ky - c_pd;
                            if (ix >= 0 && ix < c_dw && iy >= 0 && iy < c_dh)
                                sum += longint'(int'(img[c*c_dw*c_dh + iy*c_dw + ix]) *
                                                int'(ker[c*KSIZE*KSIZE + ky*KSIZE + kx]));
                        end
                acc = sum & 64'hFFFFFF;
                if (acc >= 64'h800000) acc -= 64'h1000000;
                r = acc >>> c_sh;
                if (c_relu != 0 && r < 0) r = 0;
                if (r > 127) r = 127;
                if (r < -128) r = -128;
                mdl_out[oy*c_rw + ox] = int'(r);
                push_byte(nm, oy*c_rw + ox, int'(r));
            end
        end
        cyc_q.push_back(c_rw * c_rh * (c_kw * c_kh * c_nc + 1) + 1);
    endfunction

    task automatic set_cfg(int dw, int dh, int rw, int rh, int nc, int kw, int kh,
                           int sx, int sy, int pd, int sh, int rl);
        c_dw = dw; c_dh = dh; c_rw = rw; c_rh = rh; c_nc = nc; c_kw = kw; c_kh = kh;
        c_sx = sx; c_sy = sy; c_pd = pd; c_sh = sh; c_relu = rl;
        data_width = 8'(dw);     data_height = 8'(dh);
        result_width = 8'(rw);   result_height = 8'(rh);
        channels = 3'(nc);       kernel_width = 4'(kw);  kernel_height = 4'(kh);
        stride_x = 4'(sx);       stride_y = 4'(sy);      pad = 2'(pd);
        shift = 5'(sh);          relu_en = (rl != 0);
    endtask

    task automatic load_img(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mi_wr = 1'b1; mi_addr = AW'(i); mi_data = img[i];
        end
        @(negedge clk);
        mi_wr = 1'b0;
    endtask

    task automatic load_ker();
        for (int i = 0; i < KDEP; i++) begin
            @(negedge clk);
            mk_wr = 1'b1; mk_addr = KAW'(i); mk_data = ker[i];
        end
        @(negedge clk);
        mk_wr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_runs(int target, string nm);
        int i = 0;
        while (runs_done < target && i < 25000) begin
            @(posedge clk);
            i++;
        end
        check({nm, "_completed"}, longint'(runs_done >= target), 1);
    endtask

    task automatic run_job(string nm);
        int target = runs_done + 1;
        model_job(nm);
        pulse_start();
        wait_runs(target, nm);
    endtask

    // Monitor: counts busy cycles, and on done (or an explicit request) reads back queued bytes.
    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mo_addr = AW'(e.addr);
            #1;
            check(e.name, longint'(mo_data & e.mask), longint'(e.exp));
        end
    endtask

    initial begin
        int busy_cnt = 0;
        mo_addr = '0;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            else      busy_cnt = 0;
            if (done) begin
                check("done_expected", longint'(cyc_q.size() > 0), 1);
                if (cyc_q.size() > 0) check("busy_cycles", busy_cnt, cyc_q.pop_front());
                busy_cnt = 0;
                drain();
                runs_done++;
            end else if (req_cnt != ack_cnt) begin
                drain();
                ack_cnt++;
            end
        end
    end

    initial begin
        int done_seen;
        int tgt;
        rst_n = 1'b0; start = 1'b0; mi_wr = 1'b0; mk_wr = 1'b0;
        mi_addr = '0; mi_data = '0; mk_addr = '0; mk_data = '0;
        set_cfg(4, 4, 4, 4, 1, 1, 1, 1, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        rst_n = 1'b1;

        // Identity: image 0..15, 1x1 kernel {1}; 33 busy cycles.
        for (int i = 0; i < 16; i++) img[i] = byte'(i);
        for (int i = 0; i < KDEP; i++) ker[i] = 0;
        ker[0] = 1;
        load_img(16);
        load_ker();
        set_cfg(4, 4, 4, 4, 1, 1, 1, 1, 1, 0, 0, 0);
        push_entry("ident_word0", 0, 32'h03020100, 32'hFFFFFFFF);
        run_job("ident");

        // Zero padding: 3x3 ones, 3x3 kernel ones, pad 1.
        for (int i = 0; i < 9; i++) img[i] = 1;
        for (int i = 0; i < KDEP; i++) ker[i] = 0;
        for (int ky = 0; ky < 3; ky++) for (int kx = 0; kx < 3; kx++) ker[ky*KSIZE + kx] = 1;
        load_img(9);
        load_ker();
        set_cfg(3, 3, 3, 3, 1, 3, 3, 1, 1, 1, 0, 0);
        push_byte("pad_corner", 0, 4);
        push_byte("pad_edge", 1, 6);
        push_byte("pad_centre", 4, 9);
        run_job("pad");

        // Saturation and ReLU with kernel {127}, image {127,-128}.
        img[0] = 127; img[1] = -128;
        for (int i = 0; i < KDEP; i++) ker[i] = 0;
        ker[0] = 127;
        load_img(2);
        load_ker();
        set_cfg(2, 1, 2, 1, 1, 1, 1, 1, 1, 0, 0, 0);
        push_byte("sat_hi", 0, 127);
        push_byte("sat_lo", 1, -128);
        run_job("sat");
        set_cfg(2, 1, 2, 1, 1, 1, 1, 1, 1, 0, 0, 1);
        push_byte("relu_neg", 1, 0);
        run_job("relu");
        set_cfg(2, 1, 2, 1, 1, 1, 1, 1, 1, 0, 7, 0);
        push_byte("shift7_pos", 0, 126);
        push_byte("shift7_neg", 1, -127);
        run_job("shift7");

        // Two channels, 2x2 kernels +1 / -1, stride 2 -> -4.
        for (int i = 0; i < 4; i++) begin img[i] = 2; img[4+i] = 3; end
        for (int i = 0; i < KDEP; i++) ker[i] = 0;
        for (int ky = 0; ky < 2; ky++) for (int kx = 0; kx < 2; kx++) begin
            ker[ky*KSIZE + kx] = 1;
            ker[KSIZE*KSIZE + ky*KSIZE + kx] = -1;
        end
        load_img(8);
        load_ker();
        set_cfg(2, 2, 1, 1, 2, 2, 2, 2, 2, 0, 0, 0);
        push_byte("multich", 0, -4);
        run_job("multich");

        // Randomized geometries and data.
        for (int j = 0; j < 6; j++) begin
            int dw = $urandom_range(2, 6);
            int dh = $urandom_range(2, 6);
            int nc = $urandom_range(1, 4);
            int kw = $urandom_range(1, 5);
            int kh = $urandom_range(1, 5);
            int sx = $urandom_range(1, 2);
            int sy = $urandom_range(1, 2);
            int pd = $urandom_range(0, 1);
            int rw = (dw + 2*pd - kw) / sx + 1;
            int rh = (dh + 2*pd - kh) / sy + 1;
            if (rw < 1) rw = 1;
            if (rh < 1) rh = 1;
            for (int i = 0; i < nc*dw*dh; i++) img[i] = byte'($urandom);
            for (int i = 0; i < KDEP; i++) ker[i] = byte'($urandom);
            load_img(nc*dw*dh);
            load_ker();
            set_cfg(dw, dh, rw, rh, nc, kw, kh, sx, sy, pd, $urandom_range(0, 8), $urandom_range(0, 1));
            run_job($sformatf("rand%0d", j));
        end

        // Control: start and an image write while busy are both ignored.
        for (int i = 0; i < 16; i++) img[i] = byte'(i);
        for (int i = 0; i < KDEP; i++) ker[i] = 0;
        ker[0] = 1;
        load_img(16);
        load_ker();
        set_cfg(4, 4, 4, 4, 1, 1, 1, 1, 1, 0, 0, 0);
        tgt = runs_done + 1;
        model_job("ctrl");
        pulse_start();
        @(negedge clk);
        start = 1'b1; mi_wr = 1'b1; mi_addr = AW'(5); mi_data = 8'd99;
        @(negedge clk);
        start = 1'b0; mi_wr = 1'b0;
        wait_runs(tgt, "ctrl");

        // Abort: reset mid-run with kernel {2}; later outputs keep the identity values.
        ker[0] = 2;
        load_ker();
        pulse_start();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        for (int i = 8; i < 16; i++) push_byte("abort_kept", i, mdl_out[i]);
        req_cnt++;
        for (int i = 0; i < 200 && ack_cnt != req_cnt; i++) @(posedge clk);
        check("abort_readback", ack_cnt, req_cnt);

        // A clean run after the abort starts from cleared counters and accumulator.
        ker[0] = 1;
        load_ker();
        run_job("post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
